// File: rtl/fft_digitrev_reorder_buf.sv
// fft_digitrev_reorder_buf
// Ping-pong reorder buffer: FFT output samples arrive in mixed radix-4/2
// digit-reversed stream order and leave in natural index order. One bank
// is filled while the other drains.
// Optional frame checking (in_last / err_frame) is compiled in with the
// macro FFT_REORDER_FRAMECHK_EN; without it frames are delimited by count.
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high; valid never depends on ready, and the output holds
// data/idx/last stable while out_valid & !out_ready.
module fft_digitrev_reorder_buf #(
    parameter int unsigned NPTS  = 32'd32,
    parameter int unsigned DW    = 32'd32,
    parameter int unsigned TTYPE = 32'd1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DW-1:0]           out_data,
    output logic [$clog2(NPTS)-1:0] out_idx,
    output logic                    out_last,
    output logic                    err_frame
);

    localparam int              IDXW = $clog2(NPTS);
    localparam logic [IDXW-1:0] LAST = IDXW'(NPTS - 1);

    // Stream position -> natural index. Base-4 digits are reversed; for an
    // odd index width the lone radix-2 bit (p[0]) becomes the top bit.
    function automatic logic [IDXW-1:0] stream_to_natural(input logic [IDXW-1:0] p);
        logic [IDXW-1:0] n;
        n = p;
        if (TTYPE == 1) begin
            for (int i = 0; i < IDXW / 2; i++) begin
                n[2*i +: 2] = p[(IDXW-2)-2*i +: 2];
            end
            if ((IDXW % 2) == 1) begin
                n[IDXW-1] = p[0];
            end
        end
        return n;
    endfunction

    logic [DW-1:0]   mem [0:2*NPTS-1];
    logic [IDXW-1:0] wcnt;
    logic [IDXW-1:0] rcnt;
    logic            wbank;
    logic            rbank;
    logic [1:0]      full;
    logic [1:0]      full_nxt;
    logic            wr_fire;
    logic            wr_done;
    logic            rd_issue;
    logic            rd_done;
    logic            early_last;

    assign in_ready = !full[wbank];
    assign wr_fire  = in_valid & in_ready;
    assign wr_done  = wr_fire & ((wcnt == LAST) | early_last);
    // Prefetch whenever the output register is empty or being consumed.
    assign rd_issue = full[rbank] & (!out_valid | out_ready);
    assign rd_done  = rd_issue & (rcnt == LAST);

`ifdef FFT_REORDER_FRAMECHK_EN
    assign early_last = in_last & (wcnt != LAST);

    // Sticky framing error: in_last disagrees with the sample count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_frame <= 1'b0;
        end else if (wr_fire && (in_last != (wcnt == LAST))) begin
            err_frame <= 1'b1;
        end
    end
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign early_last     = 1'b0;
    assign err_frame      = 1'b0;
`endif

    // Bank occupancy: a fill and a release in the same cycle always touch
    // different banks, so both apply.
    always_comb begin
        full_nxt = full;
        if (wr_done) full_nxt[wbank] = 1'b1;
        if (rd_done) full_nxt[rbank] = 1'b0;
    end

    // Sample storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wbank, stream_to_natural(wcnt)}] <= in_data;
        end
    end

    // Write/read counters, bank pointers and occupancy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt  <= '0;
            rcnt  <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
            full  <= 2'b00;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wcnt <= wr_done ? '0 : wcnt + 1'b1;
                if (wr_done) wbank <= !wbank;
            end
            if (rd_issue) begin
                rcnt <= rd_done ? '0 : rcnt + 1'b1;
                if (rd_done) rbank <= !rbank;
            end
        end
    end

    // One-entry output register loaded by the synchronous RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (rd_issue) begin
            out_valid <= 1'b1;
            out_data  <= mem[{rbank, rcnt}];
            out_idx   <= rcnt;
            out_last  <= (rcnt == LAST);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
